// File: rtl/bitbang_config_rx.sv
// bitbang_config_rx: receives configuration words from a bit-banged serial
// programmer. Data bits are sampled on s_clk rise and control bits on
// s_clk fall. A word is framed whenever the control history equals
// CTRL_WORD. Framed words are queued in a small FIFO for the downstream
// configuration loader.
module bitbang_config_rx #(
  parameter logic [31:0] CTRL_WORD      = 32'h0000FAB1,
  parameter int          SYNC_STAGES    = 2,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          ACTIVE_TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        s_clk,
  input  logic        s_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic        active
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            IW       = $clog2(ACTIVE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(ACTIVE_TIMEOUT);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   s_clk_s;
  logic                   s_data_s;
  logic                   s_clk_d;
  logic                   rise;
  logic                   fall;

  logic [31:0] data_sr;
  // The oldest control bit never takes part in a future comparison, so
  // only 31 bits of history are kept.
  logic [30:0] ctrl_sr;
  logic [31:0] ctrl_next;
  logic        frame_hit;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        push_ok;

  logic [IW-1:0] idle_cnt;

  // Synchronize the asynchronous serial inputs and keep a delayed s_clk copy.
  always_ff @(posedge CLK) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples pre-edge values, which is what makes the chain a chain.
    if (reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
      s_clk_d   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], s_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], s_data};
      s_clk_d   <= s_clk_s;
    end
  end

  assign s_clk_s   = clk_sync[SYNC_STAGES-1];
  assign s_data_s  = data_sync[SYNC_STAGES-1];
  assign rise      = s_clk_s & ~s_clk_d;
  assign fall      = ~s_clk_s & s_clk_d;
  assign ctrl_next = {ctrl_sr, s_data_s};
  assign frame_hit = fall && (ctrl_next == CTRL_WORD);

  // Shift data on rise, control on fall; a control match restarts framing.
  always_ff @(posedge CLK) begin
    if (reset) begin
      data_sr <= '0;
      ctrl_sr <= '0;
    end else begin
      if (rise) data_sr <= {data_sr[30:0], s_data_s};
      if (fall) ctrl_sr <= frame_hit ? '0 : ctrl_next[30:0];
    end
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = frame_hit & (~full | pop);

  // FIFO pointers, accepted-word counter and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr     <= wr_ptr + 1'b1;
        word_count <= word_count + 16'd1;
      end
      if (pop)                 rd_ptr   <= rd_ptr + 1'b1;
      if (frame_hit && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; every slot is written before
    // it can be read, and out_data is forced to zero while empty.
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data_sr;
  end

  assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : 32'h0;

  // Link activity: set on any s_clk edge, cleared after a saturating idle run.
  always_ff @(posedge CLK) begin
    if (reset) begin
      active   <= 1'b0;
      idle_cnt <= '0;
    end else if (rise || fall) begin
      active   <= 1'b1;
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_MAX - 1'b1) active <= 1'b0;
    end
  end

endmodule

// File: doc/bitbang_config_rx.md
BITBANG_CONFIG_RX -- requirements
Module: bitbang_config_rx

Interface
REQ-001 The block SHALL expose parameter CTRL_WORD, default 32'h0000FAB1, the control pattern that frames one valid configuration word.
REQ-002 The block SHALL expose parameter SYNC_STAGES, default 2 (legal 2..3), the synchronizer depth on s_clk and s_data.
REQ-003 The block SHALL expose parameter FIFO_DEPTH, default 4 (power of two, >=2), the output word buffer depth.
REQ-004 The block SHALL expose parameter ACTIVE_TIMEOUT, default 1023, the idle CLK count after which active deasserts.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_clk  input  1  asynchronous serial bit clock from the external programmer.
REQ-008 s_data  input  1  asynchronous serial data: data bit sampled at s_clk rise, control bit sampled at s_clk fall.
REQ-009 out_data  output  32  configuration word at FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  downstream configuration loader accepts the head word.
REQ-012 overflow  output  1  sticky flag: a framed word was dropped.
REQ-013 word_count  output  16  framed words accepted into the FIFO, modulo 2^16.
REQ-014 active  output  1  serial link activity indicator.

Function
REQ-015 s_clk and s_data SHALL each pass through SYNC_STAGES flip-flops; all further logic SHALL use only the synchronized values.
REQ-016 A rise (fall) event SHALL be the cycle where synchronized s_clk is 1 (0) and its one-cycle-delayed copy is 0 (1).
REQ-017 On a rise event, data_sr SHALL shift left, MSB first: data_sr <= {data_sr[30:0], s_data_sync}.
REQ-018 On a fall event, ctrl_next = {ctrl_sr[30:0], s_data_sync}; if ctrl_next == CTRL_WORD, the block SHALL push data_sr into the FIFO and load ctrl_sr with 0; otherwise ctrl_sr <= ctrl_next.
REQ-019 Framing SHALL be self-synchronizing: no bit counter; a match may occur on any fall event regardless of preceding bit count.
REQ-020 A push SHALL make out_valid visible on the CLK edge after the fall-event cycle, i.e. SYNC_STAGES+1 CLK edges after the first edge sampling s_clk low.
REQ-021 out_data/out_valid SHALL come from registered FIFO state; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 A pop SHALL occur when out_valid & out_ready at a CLK edge; words SHALL exit in push order.
REQ-023 Push when full with no simultaneous pop: word SHALL be dropped, overflow SHALL set and stay set until reset, word_count SHALL not increment.
REQ-024 Push and pop in the same cycle (including when full): both SHALL occur, occupancy unchanged, no drop.
REQ-025 Pop when empty SHALL have no effect.
REQ-026 word_count SHALL increment by 1 per accepted push and wrap 16'hFFFF -> 16'h0000.
REQ-027 active SHALL set on any rise or fall event and clear after ACTIVE_TIMEOUT consecutive cycles without an event; idle counter SHALL saturate, not wrap.
REQ-028 s_clk pulses shorter than one CLK period after synchronization are not required to be detected; the block SHALL not hang on them.

Reset
REQ-029 While reset=1 at a CLK edge: synchronizers, data_sr, ctrl_sr, FIFO pointers, word_count, overflow, active, idle counter SHALL clear to 0; out_valid=0, out_data=32'h0.
REQ-030 Reset mid-word SHALL discard the partial word; next word framing SHALL start from ctrl_sr=0.
REQ-031 Delayed s_clk copy SHALL reset to 0, so s_clk high at reset release produces one rise event.

Verification
REQ-032 Send data 32'hDEADBEEF with control 32'h0000FAB1 (5 s_clk phases of 1 CLK each per bit), out_ready=1 -> exactly one out_valid pulse with out_data=32'hDEADBEEF, word_count=1.
REQ-033 Same word with control 32'h0000FAB0 -> out_valid stays 0, word_count=0, overflow=0.
REQ-034 out_ready=0, send 5 framed words 1,2,3,4,5 -> out_valid=1, overflow=1, word_count=4; then out_ready=1 -> pops 1,2,3,4 in order, then out_valid=0.
REQ-035 FIFO full, out_ready=1 held, 6th word pushed in a pop cycle -> no drop, overflow stays 0, order preserved.
REQ-036 Assert reset after 16 bits of a word, release, send full word 32'h12345678/FAB1 -> only 32'h12345678 output, word_count=1.
REQ-037 Leave s_clk idle ACTIVE_TIMEOUT+2 cycles after a word -> active 1 during transfer, 0 afterwards; next s_clk edge sets it to 1.
